mem_port_arbiter: RTL and testbench

//  Shares one memory port between the multi-cycle CPU's instruction fetch and load/store channels.

---
 rtl/mem_port_arbiter_if.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU fetch channel, CPU load/store channel and the shared memory port.
// Suffixes are relative to the arbiter: master = arbiter view, slave = CPU/memory view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] inst_addr_i;
    logic              inst_req_valid_i;
    logic              inst_req_ready_o;
    logic [DATA_W-1:0] inst_rdata_o;
    logic              inst_valid_o;
    logic              inst_ready_i;

    logic [ADDR_W-1:0] data_addr_i;
    logic              data_wen_i;
    logic              data_ren_i;
    logic [DATA_W-1:0] data_wdata_i;
    logic [STRB_W-1:0] data_wstrb_i;
    logic              data_req_ready_o;
    logic [DATA_W-1:0] data_rdata_o;
    logic              data_rvalid_o;
    logic              data_rready_i;

    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_wen_o;
    logic              mem_ren_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [STRB_W-1:0] mem_wstrb_o;
    logic              mem_req_ready_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_rvalid_i;
    logic              mem_rready_o;

    modport master (
        input  inst_addr_i, inst_req_valid_i, inst_ready_i,
        output inst_req_ready_o, inst_rdata_o, inst_valid_o,
        input  data_addr_i, data_wen_i, data_ren_i, data_wdata_i, data_wstrb_i, data_rready_i,
        output data_req_ready_o, data_rdata_o, data_rvalid_o,
        output mem_addr_o, mem_wen_o, mem_ren_o, mem_wdata_o, mem_wstrb_o, mem_rready_o,
        input  mem_req_ready_i, mem_rdata_i, mem_rvalid_i
    );

    modport slave (
        output inst_addr_i, inst_req_valid_i, inst_ready_i,
        input  inst_req_ready_o, inst_rdata_o, inst_valid_o,
        output data_addr_i, data_wen_i, data_ren_i, data_wdata_i, data_wstrb_i, data_rready_i,
        input  data_req_ready_o, data_rdata_o, data_rvalid_o,
        input  mem_addr_o, mem_wen_o, mem_ren_o, mem_wdata_o, mem_wstrb_o, mem_rready_o,
        output mem_req_ready_i, mem_rdata_i, mem_rvalid_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
// Round-robin by default; define MEM_ARB_DATA_PRIO_EN to give load/store fixed priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.master bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [5:0] {
        IDLE   = 6'b000001,
        I_REQ  = 6'b000010,
        I_RESP = 6'b000100,
        D_WR   = 6'b001000,
        D_RD   = 6'b010000,
        D_RESP = 6'b100000
    } state_t;

    typedef enum logic {
        GRANT_INST = 1'b0,
        GRANT_DATA = 1'b1
    } grant_t;

    state_t            state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;

    logic              data_req;
    logic              grant_inst;
    logic              grant_data;

    logic              inst_req_ready;
    logic [DATA_W-1:0] inst_rdata;
    logic              inst_valid;
    logic              data_req_ready;
    logic [DATA_W-1:0] data_rdata;
    logic              data_rvalid;
    logic              mem_wen;
    logic              mem_ren;
    logic              mem_rready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_DATA;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
        end
    end

    // Only meaningful in IDLE; the FSM decides whether these become ready strobes.
    always_comb begin
        data_req = bus.data_wen_i | bus.data_ren_i;
`ifdef MEM_ARB_DATA_PRIO_EN
        grant_data = data_req;
`else
        grant_data = data_req & (~bus.inst_req_valid_i | (last_grant_q == GRANT_INST));
`endif
        grant_inst = bus.inst_req_valid_i & ~grant_data;
    end

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
        inst_req_ready = 1'b0;
        inst_rdata     = '0;
        inst_valid     = 1'b0;
        data_req_ready = 1'b0;
        data_rdata     = '0;
        data_rvalid    = 1'b0;
        mem_wen        = 1'b0;
        mem_ren        = 1'b0;
        mem_rready     = 1'b0;

        unique case (state_q)
            IDLE: begin
                inst_req_ready = grant_inst;
                data_req_ready = grant_data;
                if (grant_inst) begin
                    addr_d       = bus.inst_addr_i;
                    wdata_d      = '0;
                    wstrb_d      = '0;
                    last_grant_d = GRANT_INST;
                    state_d      = I_REQ;
                end else if (grant_data) begin
                    addr_d       = bus.data_addr_i;
                    wdata_d      = bus.data_wdata_i;
                    wstrb_d      = bus.data_wstrb_i;
                    last_grant_d = GRANT_DATA;
                    // A simultaneous store and load is treated as the store.
                    state_d      = bus.data_wen_i ? D_WR : D_RD;
                end
            end
            I_REQ: begin
                mem_ren = 1'b1;
                if (bus.mem_req_ready_i) state_d = I_RESP;
            end
            D_RD: begin
                mem_ren = 1'b1;
                if (bus.mem_req_ready_i) state_d = D_RESP;
            end
            D_WR: begin
                mem_wen = 1'b1;
                if (bus.mem_req_ready_i) state_d = IDLE;
            end
            I_RESP: begin
                inst_valid = bus.mem_rvalid_i;
                inst_rdata = bus.mem_rdata_i;
                mem_rready = bus.inst_ready_i;
                if (bus.mem_rvalid_i && bus.inst_ready_i) state_d = IDLE;
            end
            D_RESP: begin
                data_rvalid = bus.mem_rvalid_i;
                data_rdata  = bus.mem_rdata_i;
                mem_rready  = bus.data_rready_i;
                if (bus.mem_rvalid_i && bus.data_rready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.inst_req_ready_o = inst_req_ready;
    assign bus.inst_rdata_o     = inst_rdata;
    assign bus.inst_valid_o     = inst_valid;
    assign bus.data_req_ready_o = data_req_ready;
    assign bus.data_rdata_o     = data_rdata;
    assign bus.data_rvalid_o    = data_rvalid;
    assign bus.mem_addr_o       = addr_q;
    assign bus.mem_wdata_o      = wdata_q;
    assign bus.mem_wstrb_o      = wstrb_q;
    assign bus.mem_wen_o        = mem_wen;
    assign bus.mem_ren_o        = mem_ren;
    assign bus.mem_rready_o     = mem_rready;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of who gets the port next.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    // True when the load/store side was the most recent one served.
    bit modelLastData = 1'b1;

    function automatic bit pick_data(bit instPend, bit dataPend);
`ifdef MEM_ARB_DATA_PRIO_EN
        return dataPend;
`else
        return dataPend && (!instPend || !modelLastData);
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.inst_addr_i      = '0;
        bus.inst_req_valid_i = 1'b0;
        bus.inst_ready_i     = 1'b0;
        bus.data_addr_i      = '0;
        bus.data_wen_i       = 1'b0;
        bus.data_ren_i       = 1'b0;
        bus.data_wdata_i     = '0;
        bus.data_wstrb_i     = '0;
        bus.data_rready_i    = 1'b0;
        bus.mem_req_ready_i  = 1'b0;
        bus.mem_rdata_i      = '0;
        bus.mem_rvalid_i     = 1'b0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        modelLastData = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        total++; if (bus.inst_req_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_inst_req_ready got=%b exp=0", bus.inst_req_ready_o); end
        total++; if (bus.data_req_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_data_req_ready got=%b exp=0", bus.data_req_ready_o); end
        total++; if (bus.inst_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_inst_valid got=%b exp=0", bus.inst_valid_o); end
        total++; if (bus.data_rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_data_rvalid got=%b exp=0", bus.data_rvalid_o); end
        total++; if ({bus.mem_wen_o, bus.mem_ren_o, bus.mem_rready_o} !== 3'b000) begin bad++; $display("[TB] FAIL reset_mem_ctl got=%b exp=000", {bus.mem_wen_o, bus.mem_ren_o, bus.mem_rready_o}); end
        total++; if (bus.mem_addr_o !== '0) begin bad++; $display("[TB] FAIL reset_mem_addr got=%h exp=0", bus.mem_addr_o); end
        total++; if (bus.mem_wdata_o !== '0 || bus.mem_wstrb_o !== '0) begin bad++; $display("[TB] FAIL reset_mem_wdata got=%h/%h exp=0/0", bus.mem_wdata_o, bus.mem_wstrb_o); end
        total++; if (bus.inst_rdata_o !== '0 || bus.data_rdata_o !== '0) begin bad++; $display("[TB] FAIL reset_rdata got=%h/%h exp=0/0", bus.inst_rdata_o, bus.data_rdata_o); end
        rst = 1'b0;
        modelLastData = 1'b1;
    endtask

    task automatic test_fetch();
        bus.inst_addr_i      = 32'h100;
        bus.inst_req_valid_i = 1'b1;
        #1;
        total++; if (bus.inst_req_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL fetch_req_ready got=%b exp=1", bus.inst_req_ready_o); end
        step();
        modelLastData = 1'b0;
        bus.inst_req_valid_i = 1'b0;
        #1;
        total++; if (bus.mem_ren_o !== 1'b1 || bus.mem_wen_o !== 1'b0) begin bad++; $display("[TB] FAIL fetch_mem_ren got=%b%b exp=10", bus.mem_ren_o, bus.mem_wen_o); end
        total++; if (bus.mem_addr_o !== 32'h100) begin bad++; $display("[TB] FAIL fetch_mem_addr got=%h exp=100", bus.mem_addr_o); end
        step();
        step();
        total++; if (bus.mem_ren_o !== 1'b1 || bus.mem_addr_o !== 32'h100) begin bad++; $display("[TB] FAIL fetch_hold got=%b/%h exp=1/100", bus.mem_ren_o, bus.mem_addr_o); end
        bus.mem_req_ready_i = 1'b1;
        step();
        bus.mem_req_ready_i = 1'b0;
        bus.mem_rvalid_i    = 1'b1;
        bus.mem_rdata_i     = 32'h00000013;
        bus.inst_ready_i    = 1'b1;
        #1;
        total++; if (bus.inst_valid_o !== 1'b1 || bus.inst_rdata_o !== 32'h13) begin bad++; $display("[TB] FAIL fetch_resp got=%b/%h exp=1/13", bus.inst_valid_o, bus.inst_rdata_o); end
        total++; if (bus.mem_rready_o !== 1'b1 || bus.mem_ren_o !== 1'b0) begin bad++; $display("[TB] FAIL fetch_rready got=%b/%b exp=1/0", bus.mem_rready_o, bus.mem_ren_o); end
        step();
        bus.mem_rvalid_i = 1'b0;
        bus.inst_ready_i = 1'b0;
        #1;
        total++; if (bus.inst_valid_o !== 1'b0 || bus.inst_rdata_o !== '0) begin bad++; $display("[TB] FAIL fetch_done got=%b/%h exp=0/0", bus.inst_valid_o, bus.inst_rdata_o); end
        bus.inst_req_valid_i = 1'b1;
        #1;
        total++; if (bus.inst_req_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL fetch_back_idle got=%b exp=1", bus.inst_req_ready_o); end
        bus.inst_req_valid_i = 1'b0;
        #1;
    endtask

    task automatic test_round_robin();
        bit expData;
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            bus.inst_addr_i      = 32'h0;
            bus.inst_req_valid_i = 1'b1;
            bus.data_addr_i      = 32'h200;
            bus.data_ren_i       = 1'b1;
            #1;
            expData = pick_data(1'b1, 1'b1);
            total++; if (bus.data_req_ready_o !== expData || bus.inst_req_ready_o !== !expData) begin bad++; $display("[TB] FAIL rr_grant[%0d] got inst=%b data=%b exp data=%b", i, bus.inst_req_ready_o, bus.data_req_ready_o, expData); end
            step();
            modelLastData = expData;
            #1;
            total++; if (bus.mem_ren_o !== 1'b1 || bus.mem_addr_o !== (expData ? 32'h200 : 32'h0)) begin bad++; $display("[TB] FAIL rr_mem[%0d] got=%b/%h exp=1/%h", i, bus.mem_ren_o, bus.mem_addr_o, expData ? 32'h200 : 32'h0); end
            total++; if (bus.inst_req_ready_o !== 1'b0 || bus.data_req_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL rr_busy_ready[%0d] got=%b%b exp=00", i, bus.inst_req_ready_o, bus.data_req_ready_o); end
            bus.mem_req_ready_i = 1'b1;
            step();
            bus.mem_req_ready_i = 1'b0;
            bus.mem_rvalid_i    = 1'b1;
            bus.mem_rdata_i     = 32'(i);
            bus.inst_ready_i    = 1'b1;
            bus.data_rready_i   = 1'b1;
            step();
            bus.mem_rvalid_i = 1'b0;
        end
        idle_inputs();
        #1;
    endtask

    task automatic test_store();
        bus.data_addr_i  = 32'h204;
        bus.data_wdata_i = 32'h1234;
        bus.data_wstrb_i = 4'b0011;
        bus.data_wen_i   = 1'b1;
        #1;
        total++; if (bus.data_req_ready_o !== 1'b1 || bus.inst_req_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL store_req_ready got=%b/%b exp=1/0", bus.data_req_ready_o, bus.inst_req_ready_o); end
        step();
        modelLastData = 1'b1;
        bus.data_wen_i = 1'b0;
        #1;
        total++; if (bus.mem_wen_o !== 1'b1 || bus.mem_ren_o !== 1'b0) begin bad++; $display("[TB] FAIL store_mem_wen got=%b%b exp=10", bus.mem_wen_o, bus.mem_ren_o); end
        total++; if (bus.mem_addr_o !== 32'h204 || bus.mem_wdata_o !== 32'h1234 || bus.mem_wstrb_o !== 4'b0011) begin bad++; $display("[TB] FAIL store_mem_payload got=%h/%h/%b exp=204/1234/0011", bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wstrb_o); end
        bus.mem_req_ready_i = 1'b1;
        step();
        bus.mem_req_ready_i = 1'b0;
        bus.mem_rvalid_i    = 1'b1;
        bus.data_rready_i   = 1'b1;
        #1;
        total++; if (bus.mem_wen_o !== 1'b0 || bus.data_rvalid_o !== 1'b0 || bus.mem_rready_o !== 1'b0) begin bad++; $display("[TB] FAIL store_done got wen=%b rvalid=%b rready=%b exp 0/0/0", bus.mem_wen_o, bus.data_rvalid_o, bus.mem_rready_o); end
        bus.mem_rvalid_i  = 1'b0;
        bus.data_rready_i = 1'b0;
        #1;
    endtask

    task automatic test_load_stall();
        bus.data_addr_i = 32'h208;
        bus.data_ren_i  = 1'b1;
        #1;
        total++; if (bus.data_req_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL load_req_ready got=%b exp=1", bus.data_req_ready_o); end
        step();
        modelLastData = 1'b1;
        bus.data_ren_i      = 1'b0;
        bus.mem_req_ready_i = 1'b1;
        step();
        bus.mem_req_ready_i = 1'b0;
        bus.mem_rvalid_i    = 1'b1;
        bus.mem_rdata_i     = 32'hCAFE_F00D;
        bus.data_rready_i   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (bus.data_rvalid_o !== 1'b1 || bus.mem_rready_o !== 1'b0 || bus.data_rdata_o !== 32'hCAFE_F00D) begin bad++; $display("[TB] FAIL load_stall[%0d] got rvalid=%b rready=%b rdata=%h exp 1/0/cafef00d", c, bus.data_rvalid_o, bus.mem_rready_o, bus.data_rdata_o); end
            step();
        end
        bus.data_rready_i = 1'b1;
        #1;
        total++; if (bus.mem_rready_o !== 1'b1 || bus.data_rvalid_o !== 1'b1) begin bad++; $display("[TB] FAIL load_release got=%b/%b exp=1/1", bus.mem_rready_o, bus.data_rvalid_o); end
        step();
        #1;
        total++; if (bus.data_rvalid_o !== 1'b0 || bus.mem_rready_o !== 1'b0) begin bad++; $display("[TB] FAIL load_ignored_rvalid got=%b/%b exp=0/0", bus.data_rvalid_o, bus.mem_rready_o); end
        bus.mem_rvalid_i  = 1'b0;
        bus.data_rready_i = 1'b0;
        #1;
    endtask

    task automatic test_reset_midflight();
        bit expData;
        bus.inst_addr_i      = 32'h40;
        bus.inst_req_valid_i = 1'b1;
        #1;
        expData = pick_data(1'b1, 1'b0);
        total++; if (bus.inst_req_ready_o !== !expData) begin bad++; $display("[TB] FAIL midrst_fetch_grant got=%b exp=1", bus.inst_req_ready_o); end
        step();
        bus.inst_req_valid_i = 1'b0;
        bus.mem_req_ready_i  = 1'b1;
        step();
        bus.mem_req_ready_i = 1'b0;
        bus.inst_ready_i    = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        modelLastData = 1'b1;
        bus.inst_ready_i = 1'b0;
        #1;
        total++; if ({bus.inst_valid_o, bus.mem_rready_o, bus.mem_ren_o, bus.mem_wen_o} !== 4'b0000) begin bad++; $display("[TB] FAIL midrst_ctl got=%b exp=0000", {bus.inst_valid_o, bus.mem_rready_o, bus.mem_ren_o, bus.mem_wen_o}); end
        total++; if (bus.mem_addr_o !== '0) begin bad++; $display("[TB] FAIL midrst_addr got=%h exp=0", bus.mem_addr_o); end
        bus.inst_addr_i      = 32'h44;
        bus.inst_req_valid_i = 1'b1;
        bus.data_addr_i      = 32'h48;
        bus.data_ren_i       = 1'b1;
        #1;
        expData = pick_data(1'b1, 1'b1);
        total++; if (bus.data_req_ready_o !== expData || bus.inst_req_ready_o !== !expData) begin bad++; $display("[TB] FAIL midrst_grant got inst=%b data=%b exp data=%b", bus.inst_req_ready_o, bus.data_req_ready_o, expData); end
        pulse_reset();
        #1;
    endtask

    task automatic test_random();
        bit instPend = 1'b0;
        bit dataPend = 1'b0;
        logic [ADDR_W-1:0] instAddr = '0;
        logic [ADDR_W-1:0] dataAddr = '0;
        logic [DATA_W-1:0] wdata = '0;
        logic [STRB_W-1:0] wstrb = '0;
        bit wen = 1'b0;
        bit ren = 1'b0;
        bit expData, isWr;
        logic [ADDR_W-1:0] expAddr;
        logic [DATA_W-1:0] rdata;
        int kind;
        pulse_reset();
        for (int t = 0; t < 60; t++) begin
            if (!instPend && $urandom_range(0, 1) == 1) begin
                instPend = 1'b1;
                instAddr = $urandom & 32'hFFFF_FFFC;
            end
            if (!dataPend && $urandom_range(0, 1) == 1) begin
                dataPend = 1'b1;
                dataAddr = $urandom & 32'hFFFF_FFFC;
                wdata    = $urandom;
                wstrb    = 4'($urandom_range(0, 15));
                kind     = $urandom_range(0, 2);
                wen      = (kind != 0);
                ren      = (kind != 1);
            end
            if (!instPend && !dataPend) begin
                instPend = 1'b1;
                instAddr = $urandom & 32'hFFFF_FFFC;
            end
            bus.inst_addr_i      = instAddr;
            bus.inst_req_valid_i = instPend;
            bus.data_addr_i      = dataAddr;
            bus.data_wdata_i     = wdata;
            bus.data_wstrb_i     = wstrb;
            bus.data_wen_i       = dataPend & wen;
            bus.data_ren_i       = dataPend & ren;
            #1;
            expData = pick_data(instPend, dataPend);
            isWr    = expData && wen;
            expAddr = expData ? dataAddr : instAddr;
            total++; if (bus.data_req_ready_o !== expData || bus.inst_req_ready_o !== !expData) begin bad++; $display("[TB] FAIL rand_grant[%0d] got inst=%b data=%b exp data=%b", t, bus.inst_req_ready_o, bus.data_req_ready_o, expData); end
            step();
            modelLastData = expData;
            if (expData) dataPend = 1'b0; else instPend = 1'b0;
            bus.inst_req_valid_i = instPend;
            bus.data_wen_i       = dataPend & wen;
            bus.data_ren_i       = dataPend & ren;
            for (int w = $urandom_range(0, 3); w >= 0; w--) begin
                bus.mem_rvalid_i = 1'($urandom_range(0, 1));
                bus.mem_rdata_i  = $urandom;
                bus.inst_ready_i = 1'b1;
                bus.data_rready_i = 1'b1;
                #1;
                total++; if (bus.mem_wen_o !== isWr || bus.mem_ren_o !== !isWr || bus.mem_addr_o !== expAddr) begin bad++; $display("[TB] FAIL rand_req[%0d] got wen=%b ren=%b addr=%h exp wen=%b addr=%h", t, bus.mem_wen_o, bus.mem_ren_o, bus.mem_addr_o, isWr, expAddr); end
                total++; if ({bus.inst_req_ready_o, bus.data_req_ready_o, bus.mem_rready_o, bus.inst_valid_o, bus.data_rvalid_o} !== 5'b0) begin bad++; $display("[TB] FAIL rand_busy[%0d] got=%b exp=00000", t, {bus.inst_req_ready_o, bus.data_req_ready_o, bus.mem_rready_o, bus.inst_valid_o, bus.data_rvalid_o}); end
                if (isWr) begin
                    total++; if (bus.mem_wdata_o !== wdata || bus.mem_wstrb_o !== wstrb) begin bad++; $display("[TB] FAIL rand_wpayload[%0d] got=%h/%b exp=%h/%b", t, bus.mem_wdata_o, bus.mem_wstrb_o, wdata, wstrb); end
                end
                if (w > 0) step();
            end
            bus.mem_rvalid_i    = 1'b0;
            bus.mem_req_ready_i = 1'b1;
            step();
            bus.mem_req_ready_i = 1'b0;
            if (!isWr) begin
                for (int d = $urandom_range(0, 2); d > 0; d--) begin
                    #1;
                    total++; if (bus.inst_valid_o !== 1'b0 || bus.data_rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL rand_rwait[%0d] got=%b%b exp=00", t, bus.inst_valid_o, bus.data_rvalid_o); end
                    step();
                end
                rdata = $urandom;
                bus.mem_rvalid_i = 1'b1;
                bus.mem_rdata_i  = rdata;
                for (int s = $urandom_range(0, 2); s >= 0; s--) begin
                    bus.inst_ready_i  = (s == 0) ? 1'b1 : 1'b0;
                    bus.data_rready_i = (s == 0) ? 1'b1 : 1'b0;
                    #1;
                    total++; if (bus.inst_valid_o !== !expData || bus.data_rvalid_o !== expData) begin bad++; $display("[TB] FAIL rand_rvalid[%0d] got inst=%b data=%b exp data=%b", t, bus.inst_valid_o, bus.data_rvalid_o, expData); end
                    total++; if ((expData ? bus.data_rdata_o : bus.inst_rdata_o) !== rdata || (expData ? bus.inst_rdata_o : bus.data_rdata_o) !== '0) begin bad++; $display("[TB] FAIL rand_rdata[%0d] got inst=%h data=%h exp=%h", t, bus.inst_rdata_o, bus.data_rdata_o, rdata); end
                    total++; if (bus.mem_rready_o !== (s == 0)) begin bad++; $display("[TB] FAIL rand_rready[%0d] got=%b exp=%b", t, bus.mem_rready_o, s == 0); end
                    step();
                end
                bus.mem_rvalid_i = 1'b0;
            end
            #1;
            total++; if (bus.mem_wen_o !== 1'b0 || bus.mem_ren_o !== 1'b0) begin bad++; $display("[TB] FAIL rand_end[%0d] got=%b%b exp=00", t, bus.mem_wen_o, bus.mem_ren_o); end
        end
        idle_inputs();
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_fetch();
        test_round_robin();
        test_store();
        test_load_stall();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
